// File: rtl/spwm_pkg.sv
// Shared types and helpers for the sine-PWM run-control sequencer.
package spwm_pkg;

  localparam int IDX_W_DEF = 16;
  // Slew arithmetic width: covers IDX_W up to 32 with a spare bit so sums never wrap.
  localparam int SLEW_W    = 33;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRECHARGE = 3'd1,
    RAMP      = 3'd2,
    RUN       = 3'd3,
    STOP      = 3'd4,
    FAULT     = 3'd5
  } state_t;

  // Move cur toward tgt by at most step. The result lies between cur and tgt,
  // so it is always a legal index value.
  function automatic logic [SLEW_W-1:0] slew_toward(input logic [SLEW_W-1:0] cur,
                                                    input logic [SLEW_W-1:0] tgt,
                                                    input logic [SLEW_W-1:0] step);
    logic [SLEW_W-1:0] diff;
    if (tgt >= cur) begin
      diff        = tgt - cur;
      slew_toward = cur + ((diff < step) ? diff : step);
    end else begin
      diff        = cur - tgt;
      slew_toward = cur - ((diff < step) ? diff : step);
    end
  endfunction

endpackage

// File: rtl/spwm_sequencer_dead_time.sv
// Per-phase dead-time generator: complementary gate pair with a guard gap on every edge.
module dead_time_unit #(
  parameter int DT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic v_in,
  output logic g_h,
  output logic g_l
);

  localparam int            CW    = $clog2(DT_CYCLES + 1);
  localparam logic [CW-1:0] DT_LD = CW'(DT_CYCLES);

  logic          v_q;
  logic          v_d;
  logic [CW-1:0] cnt;

  // Register the comparator once, blank both gates on any change, re-arm after DT_CYCLES.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= 1'b0;
      v_d <= 1'b0;
      cnt <= DT_LD;
      g_h <= 1'b0;
      g_l <= 1'b0;
    end else begin
      v_q <= v_in;
      v_d <= v_q;
      if (!en || (v_q != v_d)) begin
        cnt <= DT_LD;
        g_h <= 1'b0;
        g_l <= 1'b0;
      end else if (cnt > CW'(1)) begin
        cnt <= cnt - 1'b1;
      end else begin
        // Count expires on this edge (or has expired): drive the side matching the input.
        cnt <= '0;
        g_h <= v_q;
        g_l <= ~v_q;
      end
    end
  end

endmodule

// File: rtl/spwm_sequencer.sv
// Run-control for the 3-phase sine-PWM datapath: start-up sequencing,
// modulation-index slew, fault latch and dead-time protected gate drives.
module spwm_sequencer
  import spwm_pkg::*;
#(
  parameter int IDX_W         = IDX_W_DEF,
  parameter int DT_CYCLES     = 8,
  parameter int PRECHARGE_CYC = 1000,
  parameter int RAMP_STEP     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             fault,
  input  logic             fault_clr,
  input  logic             carrier_zero,
  input  logic [IDX_W-1:0] target_idx,
  input  logic             va_in,
  input  logic             vb_in,
  input  logic             vc_in,
  output logic [IDX_W-1:0] mod_idx,
  output logic             gen_en,
  output logic             ga_h,
  output logic             ga_l,
  output logic             gb_h,
  output logic             gb_l,
  output logic             gc_h,
  output logic             gc_l,
  output logic [2:0]       state
);

  localparam int PC_W = $clog2(PRECHARGE_CYC + 1);

  state_t           st_q, st_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IDX_W-1:0] idx_d, idx_trk, idx_dn;
  logic             dt_en;
  logic             pre_l;
  logic [2:0]       v_vec, dt_h, dt_l;

  assign state   = st_q;
  assign idx_trk = IDX_W'(slew_toward(SLEW_W'(mod_idx), SLEW_W'(target_idx), SLEW_W'(RAMP_STEP)));
  assign idx_dn  = IDX_W'(slew_toward(SLEW_W'(mod_idx), '0, SLEW_W'(RAMP_STEP)));

  // Next-state, precharge count and index update; fault beats stop beats start.
  always_comb begin
    st_d  = st_q;
    pc_d  = pc_q;
    idx_d = mod_idx;
    if (fault) begin
      st_d  = FAULT;
      idx_d = '0;
    end else begin
      case (st_q)
        IDLE: if (start) begin
          st_d = PRECHARGE;
          pc_d = PC_W'(PRECHARGE_CYC);
        end
        PRECHARGE: begin
          if (stop) st_d = IDLE;
          else begin
            pc_d = pc_q - 1'b1;
            if (pc_q <= PC_W'(1)) st_d = RAMP;
          end
        end
        RAMP, RUN: begin
          // A stop request takes this edge; the ramp-down starts at the next valley.
          if (stop) st_d = STOP;
          else if (carrier_zero) begin
            idx_d = idx_trk;
            if ((st_q == RAMP) && (idx_trk == target_idx)) st_d = RUN;
          end
        end
        STOP: if (carrier_zero) begin
          idx_d = idx_dn;
          if (idx_dn == '0) st_d = IDLE;
        end
        FAULT: if (fault_clr) st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end

  // Dead-time units follow the next state so gates drop on the same edge as the state change.
  assign dt_en = (st_d == RAMP) || (st_d == RUN) || (st_d == STOP);

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= IDLE;
      pc_q    <= '0;
      mod_idx <= '0;
      gen_en  <= 1'b0;
      pre_l   <= 1'b0;
    end else begin
      st_q    <= st_d;
      pc_q    <= pc_d;
      mod_idx <= idx_d;
      gen_en  <= dt_en;
      pre_l   <= (st_d == PRECHARGE);
    end
  end

  assign v_vec = {vc_in, vb_in, va_in};

  for (genvar p = 0; p < 3; p++) begin : g_dt
    dead_time_unit #(.DT_CYCLES(DT_CYCLES)) u_dt (
      .clk   (clk),
      .reset (reset),
      .en    (dt_en),
      .v_in  (v_vec[p]),
      .g_h   (dt_h[p]),
      .g_l   (dt_l[p])
    );
  end

  // pre_l and the dead-time flops are never high together: the units are disabled
  // during precharge and start with a full dead time when enabled.
  assign ga_h = dt_h[0];
  assign ga_l = dt_l[0] | pre_l;
  assign gb_h = dt_h[1];
  assign gb_l = dt_l[1] | pre_l;
  assign gc_h = dt_h[2];
  assign gc_l = dt_l[2] | pre_l;

endmodule

// File: tb/tb_spwm_sequencer.sv
// Scoreboard bench for spwm_sequencer: behavioural model feeds an expectation queue,
// a monitor pops and compares once per cycle; directed scenarios plus random traffic.
module tb_spwm_sequencer;

  localparam int DT   = 8;
  localparam int PCYC = 1000;
  localparam int STEP = 64;
  localparam int S_IDLE = 0, S_PRE = 1, S_RAMP = 2, S_RUN = 3, S_STOP = 4, S_FAULT = 5;

  logic        clk = 1'b0;
  logic        reset, start, stop, fault, fault_clr, carrier_zero;
  logic [15:0] target_idx;
  logic        va_in, vb_in, vc_in;
  logic [15:0] mod_idx;
  logic        gen_en, ga_h, ga_l, gb_h, gb_l, gc_h, gc_l;
  logic [2:0]  state;

  spwm_sequencer #(.IDX_W(16), .DT_CYCLES(DT), .PRECHARGE_CYC(PCYC), .RAMP_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .fault(fault),
    .fault_clr(fault_clr), .carrier_zero(carrier_zero), .target_idx(target_idx),
    .va_in(va_in), .vb_in(vb_in), .vc_in(vc_in), .mod_idx(mod_idx), .gen_en(gen_en),
    .ga_h(ga_h), .ga_l(ga_l), .gb_h(gb_h), .gb_l(gb_l), .gc_h(gc_h), .gc_l(gc_l),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { int st; int idx; int ge; int g; } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_mode, m_idx, m_pc_left, n;
  bit s1[3], s2[3], gh[3], gl[3];
  int last_dist[3];

  function automatic bit is_active(input int md);
    return (md == S_RAMP) || (md == S_RUN) || (md == S_STOP);
  endfunction

  task automatic model_reset();
    m_mode = S_IDLE; m_idx = 0; m_pc_left = 0;
    for (int p = 0; p < 3; p++) begin
      s1[p] = 0; s2[p] = 0; gh[p] = 0; gl[p] = 0; last_dist[p] = n;
    end
  endtask

  task automatic model_edge();
    int d;
    bit v[3];
    v[0] = va_in; v[1] = vb_in; v[2] = vc_in;
    if (fault) begin
      m_mode = S_FAULT; m_idx = 0;
    end else if (m_mode == S_IDLE) begin
      if (start) begin m_mode = S_PRE; m_pc_left = PCYC; end
    end else if (m_mode == S_PRE) begin
      if (stop) m_mode = S_IDLE;
      else begin
        m_pc_left--;
        if (m_pc_left == 0) m_mode = S_RAMP;
      end
    end else if (m_mode == S_RAMP || m_mode == S_RUN) begin
      if (stop) m_mode = S_STOP;
      else if (carrier_zero) begin
        d = int'(target_idx) - m_idx;
        if (d > STEP) d = STEP;
        else if (d < -STEP) d = -STEP;
        m_idx += d;
        if (m_mode == S_RAMP && m_idx == int'(target_idx)) m_mode = S_RUN;
      end
    end else if (m_mode == S_STOP) begin
      if (carrier_zero) begin
        m_idx = (m_idx > STEP) ? m_idx - STEP : 0;
        if (m_idx == 0) m_mode = S_IDLE;
      end
    end else if (m_mode == S_FAULT) begin
      if (fault_clr) m_mode = S_IDLE;
    end
    // Gate on once DT edges have passed since the last blanking event.
    for (int p = 0; p < 3; p++) begin
      if (!is_active(m_mode) || (s1[p] != s2[p])) begin
        last_dist[p] = n; gh[p] = 0; gl[p] = 0;
      end else if (n - last_dist[p] >= DT) begin
        gh[p] = s1[p]; gl[p] = !s1[p];
      end else begin
        gh[p] = 0; gl[p] = 0;
      end
      s2[p] = s1[p]; s1[p] = v[p];
    end
  endtask

  task automatic push_exp();
    exp_t e;
    bit pre;
    pre   = (m_mode == S_PRE);
    e.st  = m_mode;
    e.idx = m_idx;
    e.ge  = is_active(m_mode) ? 1 : 0;
    e.g   = int'({gh[0], gl[0] | pre, gh[1], gl[1] | pre, gh[2], gl[2] | pre});
    sb_q.push_back(e);
  endtask

  // One clock: model follows the edge, expectation queued, return at the falling edge.
  task automatic step();
    @(posedge clk);
    n++;
    if (!reset) model_reset();
    else model_edge();
    push_exp();
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("sb_state", int'(state), mon_e.st);
      chk("sb_mod_idx", int'(mod_idx), mon_e.idx);
      chk("sb_gen_en", int'(gen_en), mon_e.ge);
      chk("sb_gates", int'({ga_h, ga_l, gb_h, gb_l, gc_h, gc_l}), mon_e.g);
    end
    chk("inv_a_hl", int'(ga_h & ga_l), 0);
    chk("inv_b_hl", int'(gb_h & gb_l), 0);
    chk("inv_c_hl", int'(gc_h & gc_l), 0);
  end

  task automatic cz_pulse();
    carrier_zero = 1'b1;
    step();
    carrier_zero = 1'b0;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_state"}, int'(state), S_IDLE);
    chk({name, "_idx"}, int'(mod_idx), 0);
    chk({name, "_gen_en"}, int'(gen_en), 0);
    chk({name, "_gates"}, int'({ga_h, ga_l, gb_h, gb_l, gc_h, gc_l}), 0);
  endtask

  int t1_exp[4] = '{64, 128, 192, 200};
  int t5_exp[3] = '{136, 72, 50};
  int t3_exp[4] = '{136, 72, 8, 0};

  initial begin
    int pre_cnt, pre_bad, hflag, held;
    n = 0;
    reset = 1'b0; start = 0; stop = 0; fault = 0; fault_clr = 0; carrier_zero = 0;
    target_idx = 16'd0; va_in = 0; vb_in = 0; vc_in = 0;
    model_reset();
    repeat (3) step();
    chk_quiet("reset");
    reset = 1'b1;
    step();

    // 1: start-up, precharge length and index ramp
    target_idx = 16'd200; start = 1'b1;
    step();
    start = 1'b0;
    pre_cnt = 0; pre_bad = 0;
    for (int i = 0; i < PCYC + 5; i++) begin
      if (int'(state) == S_PRE) begin
        pre_cnt++;
        if ({ga_h, ga_l, gb_h, gb_l, gc_h, gc_l} != 6'b010101) pre_bad++;
      end
      step();
    end
    chk("t1_pre_len", pre_cnt, PCYC);
    chk("t1_pre_gates", pre_bad, 0);
    chk("t1_ramp", int'(state), S_RAMP);
    for (int i = 0; i < 4; i++) begin
      cz_pulse();
      chk("t1_idx", int'(mod_idx), t1_exp[i]);
      chk("t1_st", int'(state), (i == 3) ? S_RUN : S_RAMP);
      repeat (15) step();
    end

    // 2: dead time on a rising phase A, short pulse swallowed
    chk("t2_l_on", int'(ga_l), 1);
    va_in = 1'b1;
    step(); step();
    chk("t2_l_off", int'(ga_l), 0);
    repeat (DT - 1) step();
    chk("t2_h_early", int'(ga_h), 0);
    step();
    chk("t2_h_on", int'(ga_h), 1);
    va_in = 1'b0;
    repeat (20) step();
    va_in = 1'b1;
    hflag = 0;
    repeat (3) begin step(); if (ga_h) hflag = 1; end
    va_in = 1'b0;
    repeat (20) begin step(); if (ga_h) hflag = 1; end
    chk("t2_pulse_swallowed", hflag, 0);

    // 5: target drop while running, no change between valleys
    target_idx = 16'd50;
    for (int i = 0; i < 3; i++) begin
      cz_pulse();
      chk("t5_idx", int'(mod_idx), t5_exp[i]);
      held = int'(mod_idx);
      repeat (15) step();
      chk("t5_hold", int'(mod_idx), held);
    end

    // 3: back to 200 then ramp-down to idle
    target_idx = 16'd200;
    repeat (3) begin cz_pulse(); repeat (10) step(); end
    chk("t3_run200", int'(mod_idx), 200);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t3_stop", int'(state), S_STOP);
    for (int i = 0; i < 4; i++) begin
      cz_pulse();
      chk("t3_idx", int'(mod_idx), t3_exp[i]);
      if (i < 3) repeat (12) step();
    end
    chk_quiet("t3_end");

    // 4: fault in RAMP, latch and clear
    start = 1'b1; step(); start = 1'b0;
    repeat (PCYC) step();
    chk("t4_ramp", int'(state), S_RAMP);
    cz_pulse();
    repeat (4) step();
    fault = 1'b1; step();
    chk("t4_fault_st", int'(state), S_FAULT);
    chk("t4_fault_idx", int'(mod_idx), 0);
    chk("t4_fault_ge", int'(gen_en), 0);
    chk("t4_fault_gates", int'({ga_h, ga_l, gb_h, gb_l, gc_h, gc_l}), 0);
    fault = 1'b0; start = 1'b1;
    repeat (3) step();
    chk("t4_start_ign", int'(state), S_FAULT);
    start = 1'b0; fault = 1'b1; fault_clr = 1'b1;
    repeat (2) step();
    chk("t4_clr_blocked", int'(state), S_FAULT);
    fault = 1'b0;
    step();
    chk("t4_clr", int'(state), S_IDLE);
    fault_clr = 1'b0;

    // 6: asynchronous reset mid-RAMP, between edges
    start = 1'b1; step(); start = 1'b0;
    repeat (PCYC) step();
    cz_pulse();
    repeat (20) step();
    chk("t6_pre_rst_idx", int'(mod_idx), 64);
    #2 reset = 1'b0;
    #1;
    chk_quiet("t6_async");
    @(negedge clk);
    repeat (3) step();
    reset = 1'b1;
    step();

    // random traffic against the model
    for (int i = 0; i < 8000; i++) begin
      start        = ($urandom_range(0, 7) == 0);
      stop         = ($urandom_range(0, 299) == 0);
      fault        = ($urandom_range(0, 1999) == 0);
      fault_clr    = ($urandom_range(0, 9) == 0);
      carrier_zero = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0)
        target_idx = ($urandom_range(0, 9) == 0) ? 16'hFFFF - 16'($urandom_range(0, 100))
                                                 : 16'($urandom_range(0, 400));
      if ($urandom_range(0, 5) == 0) va_in = ~va_in;
      if ($urandom_range(0, 5) == 0) vb_in = ~vb_in;
      if ($urandom_range(0, 11) == 0) vc_in = ~vc_in;
      step();
    end
    start = 0; stop = 0; fault = 0; fault_clr = 0; carrier_zero = 0;
    repeat (3) step();
    #1;
    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
